// File: rtl/eth_rx_uart_dump.sv
// Dumps a received Ethernet frame from the RX buffer as 8N1 UART bytes, high byte first, one word at a time.
// Frames arriving while a dump is in progress are dropped and counted; the serial line has no flow control.
module eth_rx_uart_dump #(
  parameter int ADDR_WIDTH = 9,
  parameter int BAUD_DIV   = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  input  logic [ADDR_WIDTH:0]   frame_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [15:0]           rd_data,
  output logic                  uart_txd,
  output logic                  busy,
  output logic [7:0]            frames_dropped
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND_HI, SEND_LO, NEXT} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [15:0]         BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, rd_addr_q;
  logic [ADDR_WIDTH:0]     remain_q, len_clamped;
  logic [15:0]             word_q;
  logic                    tx_busy;
  logic [9:0]              tx_shift;
  logic [15:0]             baud_cnt;
  logic [3:0]              bit_cnt;
  logic                    accept, tx_start, tx_done;
  logic [7:0]              tx_byte;

  assign len_clamped = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
  assign accept      = frame_valid && (frame_len != '0);
  assign tx_start    = ((state_q == SEND_HI) || (state_q == SEND_LO)) && !tx_busy;
  assign tx_done     = tx_busy && (baud_cnt == BAUD_LAST) && (bit_cnt == 4'd9);
  assign tx_byte     = (state_q == SEND_HI) ? word_q[15:8] : word_q[7:0];
  assign busy        = (state_q != IDLE);
  // The RAM registers the address on the FETCH edge, so present it combinationally in FETCH.
  assign rd_addr     = (state_q == FETCH) ? addr_q : rd_addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = SEND_HI;
      SEND_HI: if (tx_done) state_d = SEND_LO;
      SEND_LO: if (tx_done) state_d = NEXT;
      NEXT:    state_d = (remain_q == 1) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      rd_addr_q      <= '0;
      remain_q       <= '0;
      word_q         <= '0;
      frames_dropped <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        addr_q   <= frame_base;
        remain_q <= len_clamped;
      end
      if (state_q == FETCH) rd_addr_q <= addr_q;
      if (state_q == LATCH) word_q <= rd_data;
      if (state_q == NEXT) begin
        remain_q <= remain_q - 1'b1;
        addr_q   <= addr_q + 1'b1;
      end
      if (frame_valid && busy && frames_dropped != 8'hFF)
        frames_dropped <= frames_dropped + 8'd1;
    end
  end

  // Serialiser: shift register holds {stop, data, start}; line reflects bit 0 for BAUD_DIV cycles each.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_byte, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      uart_txd <= 1'b0;
    end else if (tx_busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          tx_busy  <= 1'b0;
          uart_txd <= 1'b1;
        end else begin
          bit_cnt  <= bit_cnt + 4'd1;
          tx_shift <= {1'b1, tx_shift[9:1]};
          uart_txd <= tx_shift[1];
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_uart_dump.sv
// Directed bench for eth_rx_uart_dump with BAUD_DIV=4 and a synchronous-read RAM model.
module tb_eth_rx_uart_dump;
  localparam int AW = 9;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic [AW:0]   frame_len = '0;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          uart_txd, busy;
  logic [7:0]    frames_dropped;

  logic [15:0] mem [0:511];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  eth_rx_uart_dump #(.ADDR_WIDTH(AW), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_base(frame_base),
    .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data),
    .uart_txd(uart_txd), .busy(busy), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse(input logic [AW-1:0] base, input logic [AW:0] len);
    frame_base  = base;
    frame_len   = len;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    frame_base  = 9'h0AA;
    frame_len   = 10'd7;
  endtask

  // Call on a negedge; returns mid stop bit. t0 = cycle of first start-bit cycle, -1 on timeout.
  task automatic rx_byte(output logic [7:0] b, output logic stop, output int t0);
    logic [7:0] d;
    int n;
    d = 'x; stop = 1'bx; t0 = -1; n = 0;
    while (uart_txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (uart_txd === 1'b0) begin
      t0 = cyc;
      repeat (BD/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        d[i] = uart_txd;
      end
      repeat (BD) @(negedge clk);
      stop = uart_txd;
    end
    b = d;
  endtask

  initial begin
    logic [7:0] b, expb;
    logic s, seen;
    int t0, t1, t2, t3, n, mism;
    logic [7:0] exp36 [8];
    exp36 = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h80, 8'h40, 8'hFF, 8'h00};

    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 37 + 16'h1357);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_dropped", frames_dropped, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word frame
    mem[9'h010] = 16'hA55A;
    pulse(9'h010, 10'd1);
    check("busy_1w", busy, 1);
    check("rd_addr_1w", rd_addr, 9'h010);
    rx_byte(b, s, t0);
    check("byte0_1w", b, 8'hA5);
    check("stop0_1w", s, 1);
    rx_byte(b, s, t1);
    check("byte1_1w", b, 8'h5A);
    check("stop1_1w", s, 1);
    check("gap_in_word_1w", (t1 - t0 >= 40) && (t1 - t0 <= 43), 1);
    @(negedge clk);
    check("busy_in_stop_1w", busy, 1);
    repeat (4) @(negedge clk);
    check("busy_fall_1w", busy, 0);
    check("rd_addr_hold_1w", rd_addr, 9'h010);

    // Two words across the address wrap
    mem[9'h1FF] = 16'h1234;
    mem[9'h000] = 16'hBEEF;
    pulse(9'h1FF, 10'd2);
    rx_byte(b, s, t0);
    check("byte0_wrap", b, 8'h12);
    check("rd_addr0_wrap", rd_addr, 9'h1FF);
    rx_byte(b, s, t1);
    check("byte1_wrap", b, 8'h34);
    rx_byte(b, s, t2);
    check("byte2_wrap", b, 8'hBE);
    check("rd_addr1_wrap", rd_addr, 9'h000);
    rx_byte(b, s, t3);
    check("byte3_wrap", b, 8'hEF);
    check("gap_between_words", (t2 - t1 >= 40) && (t2 - t1 <= 45), 1);
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_wrap", busy, 0);

    // Zero length frame is ignored
    pulse(9'h0AB, 10'd0);
    check("busy_len0", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_txd !== 1'b1 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("idle_len0", seen, 0);
    check("dropped_len0", frames_dropped, 0);

    // 300 frame_valid cycles during a 4-word dump
    mem[9'h100] = 16'hC001;
    mem[9'h101] = 16'h0203;
    mem[9'h102] = 16'h8040;
    mem[9'h103] = 16'hFF00;
    pulse(9'h100, 10'd4);
    fork
      begin
        frame_base  = 9'h005;
        frame_len   = 10'd3;
        frame_valid = 1'b1;
        repeat (300) @(negedge clk);
        frame_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          rx_byte(b, s, t0);
          check($sformatf("byte%0d_drop", k), b, exp36[k]);
        end
      end
    join
    check("dropped_sat", frames_dropped, 255);
    repeat (8) @(negedge clk);
    check("busy_after_drop", busy, 0);

    // Reset in the middle of the first byte
    mem[9'h020] = 16'h1234;
    mem[9'h030] = 16'h00FF;
    pulse(9'h020, 10'd1);
    n = 0;
    while (uart_txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_before_rst", uart_txd, 0);
    repeat (3 * BD + 1) @(negedge clk);
    check("bit2_before_rst", uart_txd, 0);
    rst = 1'b1;
    frame_valid = 1'b1;
    frame_base = 9'h030;
    frame_len = 10'd1;
    @(negedge clk);
    check("txd_after_rst", uart_txd, 1);
    check("busy_after_rst", busy, 0);
    check("dropped_after_rst", frames_dropped, 0);
    check("rd_addr_after_rst", rd_addr, 0);
    rst = 1'b0;
    frame_valid = 1'b0;
    @(negedge clk);
    check("valid_with_rst_ignored", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (uart_txd !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("no_resume_after_rst", seen, 0);
    pulse(9'h030, 10'd1);
    rx_byte(b, s, t0);
    check("byte0_post_rst", b, 8'h00);
    rx_byte(b, s, t1);
    check("byte1_post_rst", b, 8'hFF);
    check("stop1_post_rst", s, 1);

    // Oversized frame is clamped to the buffer size
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 37 + 16'h1357);
    repeat (10) @(negedge clk);
    pulse(9'h000, 10'd600);
    n = 0;
    mism = 0;
    for (int k = 0; k < 1100; k++) begin
      rx_byte(b, s, t0);
      if (t0 < 0) break;
      expb = k[0] ? mem[(k / 2) % 512][7:0] : mem[(k / 2) % 512][15:8];
      if (b !== expb) mism++;
      n++;
    end
    check("clamp_byte_count", n, 1024);
    check("clamp_data_mismatches", mism, 0);
    check("busy_after_clamp", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
